stream_output_handler: RTL
==========================

# stream_output_handler

Engine-clock packer that turns alignment results into 128-bit stream output words for the host. It accepts individual hit reports and end-of-query notifications from the engine. It keeps a per-query hit count and maximum score, and emits one hit word per hit and one summary word per completed query. It sits between the engine result ports and the output clock-crossing buffer, which is a separate block.

## Interface
- Parameters: none; the word format is fixed at 128 bits.
- clk  in  1  engine clock
- rst  in  1  reset, synchronous, active-high
- hit_valid_in  in  1  hit report valid
- hit_rdy_out  out  1  hit report accepted when high together with hit_valid_in
- hit_ref_pos_in  in  28  reference position of hit
- hit_query_pos_in  in  16  query column of hit
- hit_query_id_in  in  16  query ID of hit
- hit_score_in  in  32  cell score, unsigned
- done_valid_in  in  1  end-of-query valid
- done_rdy_out  out  1  end-of-query accepted when high together with done_valid_in
- done_query_id_in  in  16  query ID being closed
- so_data  out  128  stream output word
- so_valid  out  1  stream output valid
- so_rdy  in  1  stream output ready

## Operation
- **Word format:**
  - [27:0] ref_pos
  - [31:28] type
  - [47:32] query_pos
  - [63:48] zero
  - [79:64] hit_count
  - [95:80] query_id
  - [127:96] score
- **Hit word:** type 4'h1. ref_pos, query_pos, query_id and score come from the hit inputs. hit_count = 0.
- **Done word:** type 4'h2, ref_pos = 0, query_pos = 0. query_id = done_query_id_in. hit_count = hits accepted since the previous done (or since reset). score = maximum hit_score_in over those hits, or 0 if there were none.
- **Output state machine**, 2 states:
  - OUT_EMPTY: so_valid = 0.
  - OUT_FULL: so_valid = 1.
  - Define load = (hit accepted) or (done accepted).
  - OUT_EMPTY → OUT_FULL on load.
  - OUT_FULL stays OUT_FULL on so_rdy & load (new word replaces old).
  - OUT_FULL → OUT_EMPTY on so_rdy & !load.
  - OUT_FULL holds on !so_rdy.
- **Ready logic:**
  - space = (state == OUT_EMPTY) | so_rdy.
  - hit_rdy_out = space.
  - done_rdy_out = space & !hit_valid_in. Hit has strict priority, so at most one input is accepted per cycle.
- **Counters:**
  - hit_cnt is 16 bits and saturates at 16'hFFFF; it does not wrap.
  - max_score is 32 bits, unsigned compare.
  - On an accepted hit: hit_cnt <= sat(hit_cnt + 1); max_score <= max(max_score, hit_score_in).
  - On an accepted done: the done word uses the pre-update hit_cnt and max_score; both then clear to 0 in the same cycle.
- **Query IDs:** hit query_id is not compared against done_query_id. The engine guarantees that one query is open at a time.

## Timing
- **Reset values:** state OUT_EMPTY, so_valid 0, so_data 128'h0, hit_cnt 0, max_score 0. Ready outputs follow the combinational rule above, so hit_rdy_out = 1 in the cycle after reset.
- **Latency:** a word accepted at edge N appears on so_data with so_valid = 1 after edge N. Input-to-output latency is 1 cycle.
- **Throughput:** 1 word per cycle while so_rdy = 1. The ready outputs are combinational on so_rdy, with no bubble.
- **Hold rule:** so_data and so_valid remain stable while so_valid & !so_rdy.
- **Simultaneous hit & done:** the hit is taken first. The done is taken on a later cycle, and its hit_count includes that hit.
- **Done with zero hits:** emits hit_count 0, score 0.
- **Reset mid-operation:** a pending output word is dropped. Counters clear, so the next done word reports only hits accepted after reset.
- **Saturation:** at hit_cnt = 16'hFFFF, further hits still emit hit words, but the count stays 16'hFFFF.

## Test plan
1. **Single hit:** ref_pos 28'h0001234, query_pos 5, query_id 7, score 100, so_rdy = 1 → one cycle later so_valid = 1 and so_data = {32'd100, 16'd7, 16'd0, 16'd0, 16'd5, 4'h1, 28'h0001234}.
2. **Three hits then done:** hits with scores 10, 50, 30, then done with query_id 7 → three hit words, then the done word {32'd50, 16'd7, 16'd3, 16'd0, 16'd0, 4'h2, 28'h0}. A second done with query_id 8 right after → hit_count 0, score 0.
3. **Backpressure:** hold so_rdy = 0 for 4 cycles with hit_valid_in high → so_data stable, hit_rdy_out = 0, no word lost or duplicated. Then so_rdy = 1 with 8 back-to-back hits → 8 words on 8 consecutive cycles.
4. **Simultaneous hit and done:** hit_valid_in and done_valid_in both high in the same cycle → done_rdy_out = 0 that cycle, the hit word is emitted first, and the done word follows with hit_count including that hit.
5. **Saturation:** 65537 hits then a done → the done word has hit_count 16'hFFFF.
6. **Reset mid-hold:** assert rst while so_valid = 1 and so_rdy = 0, after 2 hits → so_valid = 0 after the reset edge. A subsequent done reports hit_count 0, score 0.

Source files
------------

// File: rtl/stream_output_handler.sv
// stream_output_handler
// Packs engine hit reports and end-of-query notifications into 128-bit
// stream output words. A single output register is refilled every cycle
// the downstream buffer is ready, so throughput is one word per cycle.
// Per-query hit count (saturating) and maximum score are accumulated
// between done notifications and reported in the done word.

module stream_output_handler (
    input  logic         clk,
    input  logic         rst,

    input  logic         hit_valid_in,
    output logic         hit_rdy_out,
    input  logic [27:0]  hit_ref_pos_in,
    input  logic [15:0]  hit_query_pos_in,
    input  logic [15:0]  hit_query_id_in,
    input  logic [31:0]  hit_score_in,

    input  logic         done_valid_in,
    output logic         done_rdy_out,
    input  logic [15:0]  done_query_id_in,

    output logic [127:0] so_data,
    output logic         so_valid,
    input  logic         so_rdy
);

    // Output word layout, most significant field first.
    typedef struct packed {
        logic [31:0] score;      // [127:96]
        logic [15:0] query_id;   // [95:80]
        logic [15:0] hit_count;  // [79:64]
        logic [15:0] zero;       // [63:48]
        logic [15:0] query_pos;  // [47:32]
        logic [3:0]  word_type;  // [31:28]
        logic [27:0] ref_pos;    // [27:0]
    } so_word_t;

    localparam logic [3:0]  TYPE_HIT  = 4'h1;
    localparam logic [3:0]  TYPE_DONE = 4'h2;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e  state_q,     state_d;
    so_word_t    so_data_q,   so_data_d;
    logic        so_valid_q,  so_valid_d;
    logic [15:0] hit_cnt_q,   hit_cnt_d;
    logic [31:0] max_score_q, max_score_d;

    logic space;
    logic hit_acc;
    logic done_acc;
    logic load;

    // Accept logic: the output register has room when empty or when it is
    // being drained this cycle; hits take strict priority over done.
    always_comb begin
        space    = (state_q == OUT_EMPTY) | so_rdy;
        hit_acc  = hit_valid_in & space;
        done_acc = done_valid_in & space & ~hit_valid_in;
        load     = hit_acc | done_acc;
    end

    assign hit_rdy_out  = space;
    assign done_rdy_out = space & ~hit_valid_in;
    assign so_data      = so_data_q;
    assign so_valid     = so_valid_q;

    // Next-state computation for the output FSM, output word and counters.
    always_comb begin
        // NOTE: every variable gets a hold default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        so_data_d   = so_data_q;
        hit_cnt_d   = hit_cnt_q;
        max_score_d = max_score_q;

        if (state_q == OUT_EMPTY) begin
            if (load) begin
                state_d = OUT_FULL;
            end
        end else begin
            if (so_rdy && !load) begin
                state_d = OUT_EMPTY;
            end
        end
        so_valid_d = (state_d == OUT_FULL);

        if (hit_acc) begin
            so_data_d.score     = hit_score_in;
            so_data_d.query_id  = hit_query_id_in;
            so_data_d.hit_count = 16'h0;
            so_data_d.zero      = 16'h0;
            so_data_d.query_pos = hit_query_pos_in;
            so_data_d.word_type = TYPE_HIT;
            so_data_d.ref_pos   = hit_ref_pos_in;

            if (hit_cnt_q != CNT_MAX) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end
            if (hit_score_in > max_score_q) begin
                max_score_d = hit_score_in;
            end
        end else if (done_acc) begin
            // The done word reports the totals accumulated before this cycle.
            so_data_d.score     = max_score_q;
            so_data_d.query_id  = done_query_id_in;
            so_data_d.hit_count = hit_cnt_q;
            so_data_d.zero      = 16'h0;
            so_data_d.query_pos = 16'h0;
            so_data_d.word_type = TYPE_DONE;
            so_data_d.ref_pos   = 28'h0;

            hit_cnt_d   = 16'h0;
            max_score_d = 32'h0;
        end
    end

    // State register; a synchronous reset drops any pending word and
    // clears the per-query accumulators.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (rst) begin
            state_q     <= OUT_EMPTY;
            so_valid_q  <= 1'b0;
            so_data_q   <= '0;
            hit_cnt_q   <= 16'h0;
            max_score_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            so_valid_q  <= so_valid_d;
            so_data_q   <= so_data_d;
            hit_cnt_q   <= hit_cnt_d;
            max_score_q <= max_score_d;
        end
    end

endmodule
